// File: rtl/softmax_pkg.sv
// Shared types and helpers for the softmax datapath: Q6.10 widths, the RU result record
// and the saturating accumulator add.
package softmax_pkg;

   localparam int unsigned DATA_W    = 16;
   localparam int unsigned FRAC_BITS = 10;
   localparam int unsigned SUM_W_MAX = 32;

   typedef struct packed {
      logic [DATA_W-1:0]    x;
      logic [DATA_W-1:0]    pow;
      logic                 last;
      logic [SUM_W_MAX-1:0] sum;
   } ru_result_t;

   // Unsigned add that clamps at 2^width-1; width must not exceed SUM_W_MAX.
   function automatic logic [SUM_W_MAX-1:0] sat_add(input logic [SUM_W_MAX-1:0] acc,
                                                    input logic [DATA_W-1:0]    val,
                                                    input int unsigned          width);
      logic [SUM_W_MAX:0] total;
      logic [SUM_W_MAX:0] limit;
      total = {1'b0, acc} + {{(SUM_W_MAX + 1 - DATA_W){1'b0}}, val};
      limit = ({{SUM_W_MAX{1'b0}}, 1'b1} << width) - {{SUM_W_MAX{1'b0}}, 1'b1};
      if (total > limit) begin
         return limit[SUM_W_MAX-1:0];
      end
      return total[SUM_W_MAX-1:0];
   endfunction

endpackage

// File: rtl/ru_fwft_fifo.sv
// First-word-fall-through FIFO with occupancy count; writes into a full FIFO are dropped.
module ru_fwft_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_wr,
   input  logic [WIDTH-1:0]           i_wdata,
   input  logic                       i_rd,
   output logic                       o_valid,
   output logic [WIDTH-1:0]           o_rdata,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             wr_en, rd_en;

   always_comb begin
      wr_en    = i_wr && (count_q != FULL);
      rd_en    = i_rd && (count_q != '0);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (rd_en) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({wr_en, rd_en})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is deliberately left out of reset; it is only visible through a valid head.
   always_ff @(posedge i_clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= i_wdata;
      end
   end

   assign o_valid = (count_q != '0);
   assign o_rdata = mem_q[rd_ptr_q];
   assign o_count = count_q;

endmodule

// File: rtl/ru_result_collector.sv
// Collects RU results into a FWFT FIFO, tags vector ends with a saturating pow2 sum,
// and throttles the RU through its clock enable so the FIFO never overruns.
module ru_result_collector
   import softmax_pkg::*;
#(
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned VEC_LEN = 64,
   parameter int unsigned SUM_W   = 32
) (
   input  logic              i_clk,
   input  logic              i_rst,
   output logic              o_ru_en,
   input  logic              i_ru_valid,
   input  logic [15:0]       i_ru_x,
   input  logic [15:0]       i_ru_pow,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [15:0]       o_x,
   output logic [15:0]       o_pow,
   output logic              o_last,
   output logic [SUM_W-1:0]  o_sum
);

   localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
   localparam int unsigned ELEM_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
   localparam logic [CNT_W-1:0]  EN_LIMIT = CNT_W'(DEPTH - 2);
   localparam logic [ELEM_W-1:0] LAST_IDX = ELEM_W'(VEC_LEN - 1);

   logic              en_q, en_d;
   logic [ELEM_W-1:0] elem_cnt_q, elem_cnt_d;
   logic [SUM_W-1:0]  acc_q, acc_d, acc_next;
   logic              cap, last, pop;
   ru_result_t        wr_entry, head;
   logic              head_valid;
   logic [CNT_W-1:0]  count;

   // RU outputs only change on an enabled edge, so a result is new only while en_q is set.
   always_comb begin
      cap        = i_ru_valid & en_q;
      last       = (elem_cnt_q == LAST_IDX);
      acc_next   = SUM_W'(sat_add(SUM_W_MAX'(acc_q), i_ru_pow, SUM_W));
      en_d       = o_ru_en;
      elem_cnt_d = elem_cnt_q;
      acc_d      = acc_q;
      wr_entry.x    = i_ru_x;
      wr_entry.pow  = i_ru_pow;
      wr_entry.last = last;
      wr_entry.sum  = last ? SUM_W_MAX'(acc_next) : '0;
      if (cap) begin
         if (last) begin
            elem_cnt_d = '0;
            acc_d      = '0;
         end else begin
            elem_cnt_d = elem_cnt_q + 1'b1;
            acc_d      = acc_next;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         en_q       <= 1'b0;
         elem_cnt_q <= '0;
         acc_q      <= '0;
      end else begin
         en_q       <= en_d;
         elem_cnt_q <= elem_cnt_d;
         acc_q      <= acc_d;
      end
   end

   ru_fwft_fifo #(
      .WIDTH ($bits(ru_result_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_wr    (cap),
      .i_wdata (wr_entry),
      .i_rd    (pop),
      .o_valid (head_valid),
      .o_rdata (head),
      .o_count (count)
   );

   // Two free slots cover the capture already in flight plus one more enabled advance.
   assign o_ru_en = (count <= EN_LIMIT);
   assign pop     = head_valid & i_ready;

   assign o_valid = head_valid;
   assign o_x     = head_valid ? head.x    : '0;
   assign o_pow   = head_valid ? head.pow  : '0;
   assign o_last  = head_valid ? head.last : 1'b0;
   assign o_sum   = head_valid ? SUM_W'(head.sum) : '0;

endmodule

// File: tb/tb_ru_result_collector.sv
// Bench for ru_result_collector: an enable-gated RU stand-in feeds the DUT and a queue-based
// model of the collector predicts every output cycle by cycle.
module tb_ru_result_collector;

   localparam int DEPTH   = 8;
   localparam int VEC_LEN = 4;
   localparam int SUM_W   = 16;

   typedef struct {
      logic [15:0] x;
      logic [15:0] pow;
   } stim_t;

   typedef struct {
      logic [15:0] x;
      logic [15:0] pow;
      logic        last;
      logic [15:0] sum;
   } res_t;

   logic             clk;
   logic             rst;
   logic             ru_en;
   logic             ru_valid;
   logic [15:0]      ru_x;
   logic [15:0]      ru_pow;
   logic             valid;
   logic             ready;
   logic [15:0]      x;
   logic [15:0]      pow;
   logic             last;
   logic [SUM_W-1:0] sum;

   stim_t       stim_q[$];
   res_t        mq[$];
   res_t        log_q[$];
   bit          m_en;
   int          m_elem;
   int unsigned m_acc;
   int          bubble_pct;
   int          checks;
   int          failures;

   ru_result_collector #(
      .DEPTH   (DEPTH),
      .VEC_LEN (VEC_LEN),
      .SUM_W   (SUM_W)
   ) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .o_ru_en    (ru_en),
      .i_ru_valid (ru_valid),
      .i_ru_x     (ru_x),
      .i_ru_pow   (ru_pow),
      .o_valid    (valid),
      .i_ready    (ready),
      .o_x        (x),
      .o_pow      (pow),
      .o_last     (last),
      .o_sum      (sum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock: predict capture/pop, advance model and RU stand-in, compare all outputs.
   task automatic tick();
      int          sz;
      bit          cap, pop, adv;
      res_t        e;
      res_t        h;
      int unsigned nacc;
      logic [50:0] got, exp;
      logic        exp_en;
      stim_t       s;
      sz  = mq.size();
      cap = !rst && ru_valid && m_en;
      pop = !rst && (sz != 0) && ready;
      adv = (sz <= DEPTH - 2);
      e.x    = ru_x;
      e.pow  = ru_pow;
      e.last = (m_elem == VEC_LEN - 1);
      nacc   = m_acc + ru_pow;
      if (nacc > 32'hFFFF) nacc = 32'hFFFF;
      e.sum  = e.last ? nacc[15:0] : 16'h0;
      if (pop) log_q.push_back('{x: x, pow: pow, last: last, sum: sum});
      if (cap && sz == DEPTH && !pop) begin
         failures++;
         $display("FAIL overflow_capture t=%0t count=%0d required<%0d", $time, sz, DEPTH);
      end
      @(posedge clk);
      if (rst) begin
         mq.delete();
         m_elem = 0;
         m_acc  = 0;
         m_en   = 1'b0;
      end else begin
         if (pop) void'(mq.pop_front());
         if (cap) begin
            mq.push_back(e);
            if (e.last) begin
               m_elem = 0;
               m_acc  = 0;
            end else begin
               m_elem++;
               m_acc = nacc;
            end
         end
         m_en = adv;
      end
      #1;
      if (adv) begin
         if (stim_q.size() != 0 && $urandom_range(99) >= bubble_pct) begin
            s        = stim_q.pop_front();
            ru_valid = 1'b1;
            ru_x     = s.x;
            ru_pow   = s.pow;
         end else begin
            ru_valid = 1'b0;
         end
      end
      exp_en = (mq.size() <= DEPTH - 2);
      if (mq.size() != 0) begin
         h   = mq[0];
         exp = {1'b1, exp_en, h.x, h.pow, h.last, h.sum};
      end else begin
         exp = {1'b0, exp_en, 49'h0};
      end
      got = {valid, ru_en, x, pow, last, sum};
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL cycle_outputs t=%0t got={v,en,x,pow,last,sum}=%h required=%h",
                  $time, got, exp);
      end
   endtask

   task automatic run_until_idle(input string name, input int budget);
      int n = 0;
      while ((mq.size() != 0 || stim_q.size() != 0 || (ru_valid && m_en)) && n < budget) begin
         tick();
         n++;
      end
      checks++;
      if (n >= budget) begin
         failures++;
         $display("FAIL %s_timeout got=%0d cycles required<%0d", name, n, budget);
      end
   endtask

   task automatic push(input logic [15:0] px, input logic [15:0] ppow);
      stim_q.push_back('{x: px, pow: ppow});
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checks++;
      if ({valid, sum, ru_en} !== {1'b0, 16'h0, 1'b1}) begin
         failures++;
         $display("FAIL reset_state got v=%b sum=%h en=%b required v=0 sum=0 en=1",
                  valid, sum, ru_en);
      end
      tick();
   endtask

   task automatic test_single_vector();
      logic [15:0] pows [4];
      logic [15:0] sums [4];
      pows = '{16'h0400, 16'h0200, 16'h0100, 16'h0080};
      sums = '{16'h0, 16'h0, 16'h0, 16'h0780};
      log_q.delete();
      ready      = 1'b1;
      bubble_pct = 0;
      for (int i = 0; i < 4; i++) push(16'(i + 1), pows[i]);
      run_until_idle("single_vector", 50);
      checks++;
      if (log_q.size() != 4) begin
         failures++;
         $display("FAIL single_count got=%0d required=4", log_q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if ({log_q[i].pow, log_q[i].last, log_q[i].sum} !== {pows[i], i == 3, sums[i]}) begin
               failures++;
               $display("FAIL single_elem%0d got pow=%h last=%b sum=%h required pow=%h last=%b sum=%h",
                        i, log_q[i].pow, log_q[i].last, log_q[i].sum, pows[i], i == 3, sums[i]);
            end
         end
      end
   endtask

   task automatic test_stall_hold();
      log_q.delete();
      ready      = 1'b0;
      bubble_pct = 0;
      for (int i = 0; i < 12; i++) push(16'h0100 + 16'(i), 16'(i + 1));
      for (int i = 0; i < 12; i++) tick();
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (ru_en !== 1'b0) begin
            failures++;
            $display("FAIL stall_en got=%b required=0", ru_en);
         end
      end
      ready = 1'b1;
      run_until_idle("stall_hold", 100);
      checks++;
      if (log_q.size() != 12) begin
         failures++;
         $display("FAIL stall_count got=%0d required=12", log_q.size());
      end else begin
         for (int i = 0; i < 12; i++) begin
            checks++;
            if (log_q[i].x !== 16'h0100 + 16'(i)) begin
               failures++;
               $display("FAIL stall_order%0d got=%h required=%h", i, log_q[i].x, 16'h0100 + i);
            end
         end
      end
   endtask

   task automatic test_full_backpressure();
      logic [15:0] xs[$];
      logic [15:0] v;
      log_q.delete();
      ready      = 1'b0;
      bubble_pct = 30;
      for (int i = 0; i < 24; i++) begin
         v = 16'($urandom);
         xs.push_back(v);
         push(v, 16'($urandom_range(16'h0800)));
      end
      for (int i = 0; i < 40; i++) tick();
      checks++;
      if ({valid, ru_en} !== 2'b10) begin
         failures++;
         $display("FAIL full_state got v=%b en=%b required v=1 en=0", valid, ru_en);
      end
      ready = 1'b1;
      run_until_idle("full_backpressure", 200);
      checks++;
      if (log_q.size() != 24) begin
         failures++;
         $display("FAIL full_count got=%0d required=24", log_q.size());
      end else begin
         for (int i = 0; i < 24; i++) begin
            checks++;
            if (log_q[i].x !== xs[i]) begin
               failures++;
               $display("FAIL full_order%0d got=%h required=%h", i, log_q[i].x, xs[i]);
            end
         end
      end
      bubble_pct = 0;
   endtask

   task automatic test_cap_pop_steady();
      int n = 0;
      log_q.delete();
      ready      = 1'b0;
      bubble_pct = 0;
      for (int i = 0; i < 16; i++) push(16'h0200 + 16'(i), 16'h0010);
      while (mq.size() != 4 && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (n >= 20) begin
         failures++;
         $display("FAIL cap_pop_fill got=%0d cycles required<20", n);
      end
      ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if ({valid, ru_en} !== 2'b11) begin
            failures++;
            $display("FAIL cap_pop_steady%0d got v=%b en=%b required v=1 en=1", i, valid, ru_en);
         end
      end
      run_until_idle("cap_pop", 60);
      checks++;
      if (log_q.size() != 16) begin
         failures++;
         $display("FAIL cap_pop_count got=%0d required=16", log_q.size());
      end else begin
         for (int i = 0; i < 16; i++) begin
            checks++;
            if (log_q[i].x !== 16'h0200 + 16'(i)) begin
               failures++;
               $display("FAIL cap_pop_order%0d got=%h required=%h", i, log_q[i].x, 16'h0200 + i);
            end
         end
      end
   endtask

   task automatic test_saturation();
      log_q.delete();
      ready = 1'b1;
      push(16'h0001, 16'hFFFF);
      push(16'h0002, 16'h0001);
      push(16'h0003, 16'h0005);
      push(16'h0004, 16'h0002);
      run_until_idle("saturation", 50);
      checks++;
      if (log_q.size() != 4 || log_q[3].last !== 1'b1 || log_q[3].sum !== 16'hFFFF) begin
         failures++;
         $display("FAIL saturation got n=%0d sum=%h required n=4 last=1 sum=ffff",
                  log_q.size(), (log_q.size() == 4) ? log_q[3].sum : 16'hxxxx);
      end
   endtask

   task automatic test_reset_mid_vector();
      int n = 0;
      ready = 1'b0;
      push(16'h0301, 16'h0100);
      push(16'h0302, 16'h0100);
      while ((stim_q.size() != 0 || (ru_valid && m_en)) && n < 10) begin
         tick();
         n++;
      end
      checks++;
      if (valid !== 1'b1 || n >= 10) begin
         failures++;
         $display("FAIL midvec_loaded got v=%b cycles=%0d required v=1", valid, n);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({valid, sum, ru_en} !== {1'b0, 16'h0, 1'b1}) begin
         failures++;
         $display("FAIL midvec_reset got v=%b sum=%h en=%b required v=0 sum=0 en=1",
                  valid, sum, ru_en);
      end
      log_q.delete();
      ready = 1'b1;
      for (int i = 0; i < 4; i++) push(16'h0310 + 16'(i), 16'(16'h10 * (i + 1)));
      run_until_idle("reset_mid_vector", 50);
      checks++;
      if (log_q.size() != 4 || log_q[0].last !== 1'b0 || log_q[3].last !== 1'b1 ||
          log_q[3].sum !== 16'h00A0) begin
         failures++;
         $display("FAIL midvec_fresh got n=%0d sum=%h required n=4 last on 4th sum=00a0",
                  log_q.size(), (log_q.size() == 4) ? log_q[3].sum : 16'hxxxx);
      end
   endtask

   task automatic test_random();
      int n = 0;
      bubble_pct = 20;
      for (int i = 0; i < 200; i++) begin
         push(16'($urandom), ($urandom_range(3) == 0) ? 16'($urandom) : 16'($urandom_range(16'h0FFF)));
      end
      while ((stim_q.size() != 0 || (ru_valid && m_en)) && n < 3000) begin
         ready = 1'($urandom_range(1));
         tick();
         n++;
      end
      ready = 1'b1;
      run_until_idle("random", 100);
      bubble_pct = 0;
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      rst        = 1'b1;
      ready      = 1'b0;
      ru_valid   = 1'b0;
      ru_x       = '0;
      ru_pow     = '0;
      m_en       = 1'b0;
      m_elem     = 0;
      m_acc      = 0;
      bubble_pct = 0;
      test_reset();
      test_single_vector();
      test_stall_hold();
      test_full_backpressure();
      test_cap_pop_steady();
      test_saturation();
      test_reset_mid_vector();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ru_result_collector.md
# ru_result_collector

Output-side collector for the softmax reduction unit (RU). It samples the RU result stream (x bypass and pow2 value), buffers results in a small first-word-fall-through FIFO, and presents them downstream on a ready/valid handshake. It also accumulates the pow2 values of each vector into a per-vector sum and tags the final element. It throttles the RU by driving the RU clock enable, so the RU pipeline freezes instead of overrunning the FIFO.

## Interface
Parameters:
- DEPTH, 8: FIFO entries; power of two, at least 4.
- VEC_LEN, 64: elements per softmax vector; at least 1.
- SUM_W, 32: accumulator width, unsigned.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- o_ru_en  out  1  enable driven to the RU i_en.
- i_ru_valid  in  1  RU o_valid.
- i_ru_x  in  16  RU o_out0, the x bypass in Q6.10.
- i_ru_pow  in  16  RU o_out1, the pow2(x) value in Q6.10, unsigned.
- o_valid  out  1  FIFO head valid.
- i_ready  in  1  downstream accepts the head.
- o_x  out  16  head x.
- o_pow  out  16  head pow.
- o_last  out  1  head is element VEC_LEN-1 of its vector.
- o_sum  out  SUM_W  vector sum of pow; meaningful only when o_last=1, else 0.

## Operation
- **RU outputs are registers gated by enable.** A new RU result exists only when enable was high on the preceding edge.
  - en_q <= o_ru_en on every edge.
  - Capture condition: cap = i_ru_valid & en_q.
  - A held i_ru_valid while en_q=0 is never captured a second time.
- **Throttle.** o_ru_en = (count <= DEPTH-2), using the registered occupancy count. There is no combinational path from any input to o_ru_en. The two-slot margin covers one capture in flight plus one enabled advance.
- **Capture.**
  - On cap, write {x, pow, last, sum} at the write pointer.
  - Increment elem_cnt, which counts 0..VEC_LEN-1.
  - last = (elem_cnt == VEC_LEN-1).
  - Accumulation: acc_next = acc + zero_ext(pow), saturating at 2^SUM_W-1.
  - If last: the stored sum = acc_next, then acc <= 0 and elem_cnt <= 0.
  - Otherwise: acc <= acc_next, and the stored sum = 0.
- **Pop.**
  - pop = o_valid & i_ready.
  - Outputs show the entry at the read pointer, first-word fall-through.
- **Simultaneous cap and pop:** count is unchanged and both pointers advance.
- **Pointers:** log2(DEPTH) bits wide, wrapping naturally from DEPTH-1 to 0.
- **Boundary conditions.**
  - Pop when empty: impossible because o_valid=0; i_ready is ignored.
  - Cap when count==DEPTH: must not occur. A bench assertion flags it. If it does occur, RTL drops the write and leaves count unchanged.
  - i_ready held low indefinitely: the FIFO fills to DEPTH-1 or DEPTH, o_ru_en drops, and no data is lost.
- **Reset** (any cycle, including mid-vector):
  - count, pointers, elem_cnt, acc and en_q are cleared to 0.
  - FIFO contents are not cleared; they are unobservable.
  - Reset values: o_valid=0, o_x=0, o_pow=0, o_last=0, o_sum=0. Outputs are forced to 0 while empty.
  - o_ru_en=1 from the first cycle after reset.

## Timing
- **Capture latency:** an RU result that is visible with en_q=1 in cycle t is written at the end of cycle t. o_valid rises in cycle t+1 if the FIFO was empty.
- **Throttle response:** count crossing to DEPTH-1 drops o_ru_en in the same cycle (count is registered). At most one further capture occurs, the one already signalled by en_q.
- **Re-enable:** a pop that lowers count to DEPTH-2 raises o_ru_en in the next cycle. The RU then resumes, and the next capture is possible 2 cycles after the pop.
- **Throughput:** 1 result per cycle whenever i_ready=1 continuously.

## Structure
- The shared package (softmax_pkg) holds:
  - the Q6.10 data width constant (16) and FRAC_BITS=10;
  - the typedef ru_result_t {x, pow, last, sum};
  - a saturating-add function for the accumulator.
- One sub-module, ru_fwft_fifo: the parameterised width/depth FWFT FIFO with count output. The capture, accumulate and throttle logic stays in ru_result_collector.

## Test plan
- **Single vector, free-flowing.** Set VEC_LEN=4, i_ready=1, and feed pow=0x0400,0x0200,0x0100,0x0080 with en_q=1. Expect:
  - 4 outputs in order;
  - o_last only on the 4th;
  - o_sum=0x0780 on the 4th, 0 on the others.
- **Stall hold.** Hold i_ru_valid=1 with fixed data while forcing the RU to see o_ru_en=0 for 5 cycles via downstream back-pressure. Expect exactly one FIFO entry for that data and no duplicates.
- **Full back-pressure.** Set DEPTH=8, i_ready=0, and stream continuously. Expect:
  - o_ru_en=0 once count reaches 7;
  - count ≤ 8 throughout, with the assertion never firing;
  - after i_ready=1, all entries drain in order with none lost.
- **Simultaneous cap and pop at count=4 for 10 cycles.** Expect count to stay at 4 and pointers to wrap past DEPTH-1 correctly.
- **Saturation.** Set SUM_W=16, VEC_LEN=3, pow=0xFFFF,0x0001,0x0005. Expect o_sum=0xFFFF on the last element.
- **Reset mid-vector.** Capture 2 of 4 elements, then assert i_rst for 1 cycle. Expect:
  - o_valid=0, o_sum=0, o_ru_en=1 next cycle;
  - the next 4 inputs form a complete vector with a fresh sum.
